// File: rtl/heartbeat_pkg.sv
// Shared definitions for the heartbeat transmitter: FSM state encoding,
// default EtherType, frame beat indices and a byte-order helper.
package heartbeat_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSend  = 2'd1,
    StGrant = 2'd2
  } hb_state_e;

  localparam logic [15:0] HB_ETHERTYPE = 16'h88B5;

  localparam logic [7:0] BEAT_ETH0    = 8'd0;
  localparam logic [7:0] BEAT_ETH1    = 8'd1;
  localparam logic [7:0] BEAT_PAYLOAD = 8'd2;

  // Fields are assembled big-endian (first wire byte in [63:56]); the stream
  // carries the first wire byte in [7:0], so every beat is byte-reversed.
  function automatic logic [63:0] bswap64(input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = w[8*(7-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/heartbeat_tx_if.sv
// 64-bit AXI-Stream link carrying heartbeat frames.
//   tdata  : beat data, first wire byte in [7:0]
//   tkeep  : byte enables (all ones while tvalid)
//   tvalid : beat valid
//   tready : sink ready
//   tlast  : final beat of a frame
interface heartbeat_tx_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/heartbeat_frame_mux.sv
// Combinational beat selector for the heartbeat frame.
//   beat_idx  : index of the beat currently offered
//   seq_num   : sequence number carried in the payload beat
//   ts_lat    : timestamp latched at frame start
//   beat_data : stream-order beat data (first wire byte in [7:0])
module heartbeat_frame_mux
  import heartbeat_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE = HB_ETHERTYPE,
  parameter logic [15:0] NODE_ID   = 16'h0001
) (
  input  logic [7:0]  beat_idx,
  input  logic [31:0] seq_num,
  input  logic [31:0] ts_lat,
  output logic [63:0] beat_data
);

  logic [63:0] be_word;

  always_comb begin
    be_word = '0;
    case (beat_idx)
      BEAT_ETH0:    be_word = {DST_MAC, SRC_MAC[47:32]};
      BEAT_ETH1:    be_word = {SRC_MAC[31:0], ETHERTYPE, NODE_ID};
      BEAT_PAYLOAD: be_word = {seq_num, ts_lat};
      default:      be_word = '0;
    endcase
  end

  assign beat_data = bswap64(be_word);

endmodule

// File: rtl/heartbeat_tx.sv
// Heartbeat frame transmitter. When the interval timer raises handshake (and
// enable is set) one fixed-length frame is sent on the AXI-Stream master, then
// grant pulses for one cycle so the timer can restart its period.
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : heartbeat enable, only looked at in idle
//   handshake  : timer period elapsed (level, held until grant)
//   grant      : one-cycle pulse after the last beat is accepted
//   m_axis     : AXI-Stream master (heartbeat_tx_if.master)
//   seq_num    : sequence number of the next frame
//   busy       : frame in progress (send or grant)
module heartbeat_tx
  import heartbeat_pkg::*;
#(
  parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE   = HB_ETHERTYPE,
  parameter logic [15:0] NODE_ID     = 16'h0001,
  parameter int unsigned FRAME_BEATS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  handshake,
  output logic                  grant,
  heartbeat_tx_if.master        m_axis,
  output logic [31:0]           seq_num,
  output logic                  busy
);

  localparam logic [7:0] LAST_BEAT = 8'(FRAME_BEATS - 1);

  hb_state_e   state_q, state_d;
  logic [7:0]  beat_cnt_q;
  logic [31:0] ts_cnt_q, ts_lat_q;
  logic [31:0] seq_q, seq_d;
  logic [63:0] beat_data;
  logic        start, beat_fire;

  assign start     = (state_q == StIdle) && handshake && enable;
  assign beat_fire = (state_q == StSend) && m_axis.tready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StSend;
      StSend:  if (beat_fire && (beat_cnt_q == LAST_BEAT)) state_d = StGrant;
      StGrant: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sequence number only advances on leaving grant, so a frame in flight
  // always carries the value it started with.
  always_comb begin
    seq_d = seq_q;
    if (state_q == StGrant) seq_d = seq_q + 32'd1;
  end

  // Counters and frame-start snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      ts_cnt_q   <= '0;
      ts_lat_q   <= '0;
      seq_q      <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      seq_q    <= seq_d;
      if (start) begin
        ts_lat_q   <= ts_cnt_q;
        beat_cnt_q <= '0;
      end else if (beat_fire) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
      end
    end
  end

  heartbeat_frame_mux #(
    .DST_MAC   (DST_MAC),
    .SRC_MAC   (SRC_MAC),
    .ETHERTYPE (ETHERTYPE),
    .NODE_ID   (NODE_ID)
  ) u_frame_mux (
    .beat_idx  (beat_cnt_q),
    .seq_num   (seq_q),
    .ts_lat    (ts_lat_q),
    .beat_data (beat_data)
  );

  // Outputs decode registered state only, so tdata/tlast hold during stalls
  // and everything drops to zero as soon as reset asserts.
  always_comb begin
    m_axis.tvalid = (state_q == StSend);
    m_axis.tlast  = m_axis.tvalid && (beat_cnt_q == LAST_BEAT);
    m_axis.tkeep  = m_axis.tvalid ? 8'hFF : 8'h00;
    m_axis.tdata  = m_axis.tvalid ? beat_data : 64'h0;
    grant         = (state_q == StGrant);
    busy          = (state_q != StIdle);
    seq_num       = seq_q;
  end

endmodule

// File: tb/tb_heartbeat_tx.sv
module tb_heartbeat_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        handshake = 1'b0;
  logic        grant;
  logic        busy;
  logic [31:0] seq_num;

  heartbeat_tx_if m_axis();

  heartbeat_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .handshake (handshake),
    .grant     (grant),
    .m_axis    (m_axis),
    .seq_num   (seq_num),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference free-running cycle counter
  logic [31:0] tb_ts;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  localparam logic [63:0] EXP_BEAT0 = 64'h0002_FFFF_FFFF_FFFF;
  localparam logic [63:0] EXP_BEAT1 = 64'h0100_B588_0100_0000;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Results of the most recent run_frame
  logic [63:0] got_data [8];
  logic [7:0]  got_last;
  int          nb, grants, stall_bad, keep_bad, first_lat, grant_cyc, last_cyc, extra_valid;
  logic [31:0] ts_exp;
  bit          timeout;

  // Drives handshake and tready (pattern indexed by cycle mod 4) and records what
  // the stream delivers. drop_beat >= 0 clears enable while that beat is offered.
  task automatic run_frame(input logic [3:0] rdy_pat, input int drop_beat);
    int          cyc;
    bit          stalled, done;
    logic [63:0] hold_data;
    logic        hold_last;
    nb = 0; grants = 0; stall_bad = 0; keep_bad = 0; first_lat = -1; grant_cyc = -1;
    last_cyc = -1; extra_valid = 0; timeout = 0; got_last = '0;
    for (int i = 0; i < 8; i++) got_data[i] = '0;
    stalled = 0; done = 0; cyc = 0; hold_data = '0; hold_last = 0;
    handshake = 1'b1;
    while (!done) begin
      @(negedge clk);
      cyc++;
      m_axis.tready = rdy_pat[cyc % 4];
      if (m_axis.tvalid) begin
        if (grant_cyc >= 0) extra_valid++;
        if (first_lat < 0) begin
          first_lat = cyc;
          ts_exp = tb_ts - 32'd1;
        end
        if (m_axis.tkeep !== 8'hFF) keep_bad++;
        if (stalled && (m_axis.tdata !== hold_data || m_axis.tlast !== hold_last)) stall_bad++;
        if (drop_beat >= 0 && nb == drop_beat) enable = 1'b0;
        if (m_axis.tready) begin
          if (nb < 8) begin
            got_data[nb] = m_axis.tdata;
            got_last[nb] = m_axis.tlast;
          end
          if (m_axis.tlast === 1'b1) last_cyc = cyc;
          nb++;
          stalled = 0;
        end else begin
          stalled = 1;
          hold_data = m_axis.tdata;
          hold_last = m_axis.tlast;
        end
      end
      if (grant === 1'b1) begin
        grants++;
        if (grant_cyc < 0) grant_cyc = cyc;
        handshake = 1'b0;
      end
      if (grant_cyc >= 0 && cyc >= grant_cyc + 3) done = 1;
      if (cyc >= 200) begin
        timeout = 1;
        done = 1;
      end
    end
    handshake = 1'b0;
    m_axis.tready = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b exp=0", m_axis.tvalid); end
    checks++; if (m_axis.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b exp=0", m_axis.tlast); end
    checks++; if (m_axis.tdata !== 64'h0) begin errors++; $display("FAIL reset_tdata got=%h exp=0", m_axis.tdata); end
    checks++; if (m_axis.tkeep !== 8'h0) begin errors++; $display("FAIL reset_tkeep got=%h exp=0", m_axis.tkeep); end
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant got=%b exp=0", grant); end
    checks++; if (seq_num !== 32'h0) begin errors++; $display("FAIL reset_seq got=%h exp=0", seq_num); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_frame();
    run_frame(4'b1111, -1);
    checks++; if (timeout) begin errors++; $display("FAIL basic_timeout got=1 exp=0"); end
    checks++; if (first_lat !== 1) begin errors++; $display("FAIL basic_first_latency got=%0d exp=1", first_lat); end
    checks++; if (nb !== 8) begin errors++; $display("FAIL basic_beats got=%0d exp=8", nb); end
    checks++; if (got_last !== 8'h80) begin errors++; $display("FAIL basic_tlast_map got=%b exp=10000000", got_last); end
    checks++; if (last_cyc !== 8) begin errors++; $display("FAIL basic_last_cycle got=%0d exp=8", last_cyc); end
    checks++; if (grant_cyc !== 9) begin errors++; $display("FAIL basic_grant_cycle got=%0d exp=9", grant_cyc); end
    checks++; if (grants !== 1) begin errors++; $display("FAIL basic_grant_count got=%0d exp=1", grants); end
    checks++; if (keep_bad !== 0) begin errors++; $display("FAIL basic_tkeep got=%0d bad exp=0", keep_bad); end
    checks++; if (got_data[0] !== EXP_BEAT0) begin errors++; $display("FAIL basic_beat0 got=%h exp=%h", got_data[0], EXP_BEAT0); end
    checks++; if (got_data[1] !== EXP_BEAT1) begin errors++; $display("FAIL basic_beat1 got=%h exp=%h", got_data[1], EXP_BEAT1); end
    checks++; if (got_data[2][31:0] !== 32'h0) begin errors++; $display("FAIL basic_beat2_seq got=%h exp=0", got_data[2][31:0]); end
    checks++; if (got_data[2][63:32] !== bswap32(ts_exp)) begin errors++; $display("FAIL basic_beat2_ts got=%h exp=%h", got_data[2][63:32], bswap32(ts_exp)); end
    for (int i = 3; i < 8; i++) begin
      checks++; if (got_data[i] !== 64'h0) begin errors++; $display("FAIL basic_beat%0d_zero got=%h exp=0", i, got_data[i]); end
    end
    checks++; if (extra_valid !== 0) begin errors++; $display("FAIL basic_retrigger got=%0d exp=0", extra_valid); end
    checks++; if (seq_num !== 32'd1) begin errors++; $display("FAIL basic_seq_after got=%h exp=1", seq_num); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    run_frame(4'b1001, -1);
    checks++; if (timeout) begin errors++; $display("FAIL bp_timeout got=1 exp=0"); end
    checks++; if (nb !== 8) begin errors++; $display("FAIL bp_beats got=%0d exp=8", nb); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bp_stall_stable got=%0d changes exp=0", stall_bad); end
    checks++; if (grants !== 1) begin errors++; $display("FAIL bp_grant_count got=%0d exp=1", grants); end
    checks++; if (grant_cyc - last_cyc !== 1) begin errors++; $display("FAIL bp_grant_latency got=%0d exp=1", grant_cyc - last_cyc); end
    checks++; if (got_last !== 8'h80) begin errors++; $display("FAIL bp_tlast_map got=%b exp=10000000", got_last); end
    checks++; if (got_data[0] !== EXP_BEAT0) begin errors++; $display("FAIL bp_beat0 got=%h exp=%h", got_data[0], EXP_BEAT0); end
    checks++; if (got_data[1] !== EXP_BEAT1) begin errors++; $display("FAIL bp_beat1 got=%h exp=%h", got_data[1], EXP_BEAT1); end
    checks++; if (got_data[2][31:0] !== 32'h0100_0000) begin errors++; $display("FAIL bp_beat2_seq got=%h exp=01000000", got_data[2][31:0]); end
    checks++; if (seq_num !== 32'd2) begin errors++; $display("FAIL bp_seq_after got=%h exp=2", seq_num); end
  endtask

  task automatic test_enable();
    int seen_valid, seen_grant;
    seen_valid = 0; seen_grant = 0;
    enable = 1'b0;
    handshake = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_axis.tvalid !== 1'b0) seen_valid++;
      if (grant !== 1'b0) seen_grant++;
    end
    handshake = 1'b0;
    checks++; if (seen_valid !== 0) begin errors++; $display("FAIL en_off_tvalid got=%0d exp=0", seen_valid); end
    checks++; if (seen_grant !== 0) begin errors++; $display("FAIL en_off_grant got=%0d exp=0", seen_grant); end
    enable = 1'b1;
    @(negedge clk);
    run_frame(4'b1111, 3);
    enable = 1'b1;
    checks++; if (nb !== 8) begin errors++; $display("FAIL en_drop_beats got=%0d exp=8", nb); end
    checks++; if (grants !== 1) begin errors++; $display("FAIL en_drop_grant got=%0d exp=1", grants); end
    checks++; if (seq_num !== 32'd3) begin errors++; $display("FAIL en_drop_seq got=%h exp=3", seq_num); end
  endtask

  task automatic test_reset_mid_frame();
    int waited;
    waited = 0;
    m_axis.tready = 1'b1;
    handshake = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (m_axis.tvalid !== 1'b1 && waited < 20);
    checks++; if (m_axis.tvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_start got=%b exp=1", m_axis.tvalid); end
    repeat (4) @(negedge clk);
    checks++; if (seq_num !== 32'd3) begin errors++; $display("FAIL rst_mid_seq_before got=%h exp=3", seq_num); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (m_axis.tvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_tvalid got=%b exp=0", m_axis.tvalid); end
    checks++; if (seq_num !== 32'd0) begin errors++; $display("FAIL rst_mid_seq got=%h exp=0", seq_num); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    handshake = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(4'b1111, -1);
    checks++; if (grants !== 1) begin errors++; $display("FAIL rst_after_grant got=%0d exp=1", grants); end
    checks++; if (nb !== 8) begin errors++; $display("FAIL rst_after_beats got=%0d exp=8", nb); end
    checks++; if (got_data[2][31:0] !== 32'h0) begin errors++; $display("FAIL rst_after_seq_field got=%h exp=0", got_data[2][31:0]); end
    checks++; if (got_data[2][63:32] !== bswap32(ts_exp)) begin errors++; $display("FAIL rst_after_ts got=%h exp=%h", got_data[2][63:32], bswap32(ts_exp)); end
    checks++; if (seq_num !== 32'd1) begin errors++; $display("FAIL rst_after_seq got=%h exp=1", seq_num); end
  endtask

  task automatic test_seq_wrap();
    force dut.seq_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.seq_q;
    @(negedge clk);
    checks++; if (seq_num !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got=%h exp=ffffffff", seq_num); end
    run_frame(4'b1111, -1);
    checks++; if (grants !== 1) begin errors++; $display("FAIL wrap_grant got=%0d exp=1", grants); end
    checks++; if (got_data[2][31:0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_seq_field got=%h exp=ffffffff", got_data[2][31:0]); end
    checks++; if (seq_num !== 32'h0) begin errors++; $display("FAIL wrap_seq_after got=%h exp=0", seq_num); end
  endtask

  initial begin
    m_axis.tready = 1'b1;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_enable();
    test_reset_mid_frame();
    test_seq_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/heartbeat_tx.md
Name: heartbeat_tx

Overview:
Downstream consumer of the heartbeat interval timer. While the timer's `handshake` is high, this block emits one fixed-length Ethernet heartbeat frame on a 64-bit AXI-Stream master. It returns a one-cycle `grant` once the last beat is accepted, which restarts the timer period. The block sits between the interval timer and the app TX stream path.

Parameters:
- DST_MAC, 48'hFFFF_FFFF_FFFF, destination MAC.
- SRC_MAC, 48'h02_00_00_00_00_01, source MAC.
- ETHERTYPE, 16'h88B5, heartbeat EtherType.
- NODE_ID, 16'h0001, sender identifier carried in the frame.
- FRAME_BEATS, 8, frame length in 64-bit beats; legal range 3..255.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  heartbeat enable; sampled only in IDLE.
- handshake  in  1  timer period elapsed; level, held until grant.
- grant  out  1  one-cycle pulse; tells timer the frame is sent.
- m_axis_tdata  out  64  frame data; first wire byte in [7:0].
- m_axis_tkeep  out  8  always 8'hFF while tvalid.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  high on beat FRAME_BEATS-1.
- seq_num  out  32  sequence number of the next frame.
- busy  out  1  high in SEND or GRANT.

Behaviour:
- Only one clock domain and one reset: `clk`, with `rst_n` asynchronous and active-low. All state clears on the falling edge of `rst_n`.
- Reset values: grant=0, tvalid=0, tlast=0, tdata=0, tkeep=0, seq_num=0, busy=0, beat_cnt=0, ts_cnt=0, state=IDLE.
- ts_cnt: 32-bit free-running cycle counter; wraps 2^32-1 -> 0.
- States: IDLE, SEND, GRANT.
- IDLE:
  - If handshake && enable: latch ts_cnt into ts_lat, go to SEND with beat_cnt=0.
  - tvalid rises on the next cycle.
  - Otherwise stay in IDLE.
- SEND:
  - tvalid=1.
  - On tvalid&&tready: beat_cnt++.
  - On acceptance of beat FRAME_BEATS-1: go to GRANT.
  - tdata/tlast stay stable while tvalid&&!tready (AXIS rule).
  - tvalid never drops mid-frame, and enable deassertion does not abort a frame.
- GRANT:
  - grant=1 for exactly one cycle; seq_num += 1 (wraps at 2^32); go to IDLE.
  - The timer drops handshake the cycle after grant, so IDLE does not re-trigger.
- Frame layout, in wire byte order (byte 0 = tdata[7:0]):
  - Beat 0: bytes 0-5 = DST_MAC, MSB first; bytes 6-7 = SRC_MAC[47:32].
  - Beat 1: bytes 0-3 = SRC_MAC[31:0]; bytes 4-5 = ETHERTYPE, MSB first; bytes 6-7 = NODE_ID, MSB first.
  - Beat 2: bytes 0-3 = seq_num, MSB first; bytes 4-7 = ts_lat, MSB first.
  - Beats 3..FRAME_BEATS-1: all zero.
- Frame contents are fixed at SEND entry. seq_num does not change until GRANT.
- Latency:
  - handshake high in IDLE -> first tvalid: 1 cycle.
  - Last beat accepted -> grant: 1 cycle.
- Reset mid-frame: tvalid drops asynchronously; the partial frame is abandoned. The downstream sink must tolerate truncation on reset.
- handshake low while in SEND/GRANT is ignored.
- tready held high: a frame takes FRAME_BEATS cycles, then 1 GRANT cycle. Minimum handshake-to-grant is FRAME_BEATS+1 cycles.

Decomposition:
- Shared package `heartbeat_pkg` holds:
  - state encodings: IDLE, SEND, GRANT;
  - HB_ETHERTYPE default;
  - beat index constants: BEAT_ETH0=0, BEAT_ETH1=1, BEAT_PAYLOAD=2.
- One natural sub-module, `heartbeat_frame_mux`: a combinational beat_cnt -> tdata mux over the header fields, seq_num and ts_lat.
- The FSM, counters and AXIS handshake stay in `heartbeat_tx`.

Test Plan:
- Reset, then enable=1, handshake=1, tready=1 -> tvalid at cycle+1 for 8 beats; tlast only on beat 7; grant pulses 1 cycle after beat 7; seq_num goes 0 -> 1.
- Beat contents, default params -> beat0=FF FF FF FF FF FF 02 00, beat1=00 00 00 01 88 B5 00 01, beat2 bytes 0-3 = 00 00 00 00; beats 3-7 zero.
- tready toggling 1,0,0,1 throughout -> tdata/tlast unchanged during stalls; all 8 beats delivered in order; exactly one grant.
- enable=0 with handshake=1 -> no tvalid, no grant. enable drops during beat 3 -> frame completes, grant issued.
- rst_n asserted during beat 4 -> tvalid=0 immediately, seq_num=0. After release with handshake=1 -> a full frame with seq=0.
- Force seq_num to 32'hFFFF_FFFF, send one frame -> payload seq=FFFFFFFF; seq_num wraps to 0 after grant.
